// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock programmable FIFO.
package sync_fifo_pkg;

  localparam int DATA_SIZE_DEF = 12;
  localparam int ADDR_SIZE_DEF = 4;

  // Read-side presentation mode selected by the FWFT parameter.
  typedef enum logic {
    RD_REG  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Number of storage words for a given address width.
  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_SIZE storage: synchronous write port, asynchronous read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with FWFT/registered read, programmable almost flags,
// occupancy count and sticky overflow/underflow flags.
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter bit FWFT      = 1'b1,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 winc,
  input  logic [DATA_SIZE-1:0] wData,
  output logic                 wFull,
  output logic                 wAlmostFull,
  input  logic                 rinc,
  output logic [DATA_SIZE-1:0] rData,
  output logic                 rEmpty,
  output logic                 rAlmostEmpty,
  output logic [ADDR_SIZE:0]   count,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int       DEPTH   = fifo_depth(ADDR_SIZE);
  localparam int       CW      = ADDR_SIZE + 1;
  localparam rd_mode_e RD_MODE = FWFT ? RD_FWFT : RD_REG;

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  if (ADDR_SIZE < 1) begin : g_bad_addr
    $fatal(1, "sync_fifo_prog: ADDR_SIZE must be >= 1");
  end
  if (!(AEMPTY_TH >= 0 && AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_th
    $fatal(1, "sync_fifo_prog: need 0 <= AEMPTY_TH < AFULL_TH <= DEPTH");
  end

  logic [ADDR_SIZE-1:0] wptr, rptr;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 wr_ok, rd_ok;
  logic [CW-1:0]        count_next;

  assign wr_ok = winc & ~wFull;
  assign rd_ok = rinc & ~rEmpty;

  // Next occupancy; every flag is registered from this value.
  always_comb begin
    count_next = count + CW'(wr_ok) - CW'(rd_ok);
  end

  sync_fifo_mem #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (wData),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  // Pointers, occupancy and status flags; sticky errors give set priority over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      wFull        <= 1'b0;
      wAlmostFull  <= 1'b0;
      rEmpty       <= 1'b1;
      rAlmostEmpty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      count        <= count_next;
      wFull        <= (count_next == DEPTH_C);
      wAlmostFull  <= (count_next >= AFULL_C);
      rEmpty       <= (count_next == '0);
      rAlmostEmpty <= (count_next <= AEMPTY_C);
      overflow     <= (winc & wFull)  | (overflow  & ~clr_err);
      underflow    <= (rinc & rEmpty) | (underflow & ~clr_err);
    end
  end

  if (RD_MODE == RD_FWFT) begin : g_fwft
    // Head word is presented straight from the memory read port.
    assign rData = mem_rdata;
  end else begin : g_reg
    logic [DATA_SIZE-1:0] rdata_q;
    // Output register loads the head word only on an accepted read.
    always_ff @(posedge clk) begin
      if (rst)        rdata_q <= '0;
      else if (rd_ok) rdata_q <= mem_rdata;
    end
    assign rData = rdata_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: one FWFT instance, one registered-read instance.
module tb_sync_fifo_prog;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_winc = 1'b0, a_rinc = 1'b0, a_clr = 1'b0;
  logic [11:0] a_wdata = '0, a_rdata;
  logic        a_wfull, a_wafull, a_rempty, a_raempty, a_ovf, a_udf;
  logic [4:0]  a_count;

  logic        b_winc = 1'b0, b_rinc = 1'b0, b_clr = 1'b0;
  logic [11:0] b_wdata = '0, b_rdata;
  logic        b_wfull, b_wafull, b_rempty, b_raempty, b_ovf, b_udf;
  logic [4:0]  b_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] q[$];
  logic [11:0] d;
  logic [11:0] last;
  logic [11:0] alt [6] = '{12'hA5A, 12'h3C3, 12'h5A5, 12'hC3C, 12'h0F0, 12'hF0F};

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_SIZE(12), .ADDR_SIZE(4), .FWFT(1'b1), .AFULL_TH(12), .AEMPTY_TH(2)) u_a (
    .clk(clk), .rst(rst), .winc(a_winc), .wData(a_wdata), .wFull(a_wfull),
    .wAlmostFull(a_wafull), .rinc(a_rinc), .rData(a_rdata), .rEmpty(a_rempty),
    .rAlmostEmpty(a_raempty), .count(a_count), .overflow(a_ovf), .underflow(a_udf),
    .clr_err(a_clr)
  );

  sync_fifo_prog #(.DATA_SIZE(12), .ADDR_SIZE(4), .FWFT(1'b0), .AFULL_TH(12), .AEMPTY_TH(2)) u_b (
    .clk(clk), .rst(rst), .winc(b_winc), .wData(b_wdata), .wFull(b_wfull),
    .wAlmostFull(b_wafull), .rinc(b_rinc), .rData(b_rdata), .rEmpty(b_rempty),
    .rAlmostEmpty(b_raempty), .count(b_count), .overflow(b_ovf), .underflow(b_udf),
    .clr_err(b_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one word into the FWFT instance and record it.
  task automatic a_write(input logic [11:0] wd);
    a_winc = 1'b1; a_wdata = wd;
    tick();
    a_winc = 1'b0;
    q.push_back(wd);
  endtask

  // Check the FWFT head against the scoreboard, then pop it.
  task automatic a_read(input string tag);
    chk(tag, a_rdata, q[0]);
    a_rinc = 1'b1;
    tick();
    a_rinc = 1'b0;
    void'(q.pop_front());
  endtask

  initial begin
    // Reset held for three cycles, then idle.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_rempty", a_rempty, 1);
    chk("rst_wfull", a_wfull, 0);
    chk("rst_count", a_count, 0);
    chk("rst_raempty", a_raempty, 1);
    chk("rst_wafull", a_wafull, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_udf", a_udf, 0);
    chk("rst_reg_rdata", b_rdata, 0);

    // Fill with 16 words, watching the almost-full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      d = 12'((i * 12'h2B7 + 12'h013) & 12'hFFF);
      a_write(d);
      chk("fill_count", a_count, i + 1);
      chk("fill_wafull", a_wafull, (i + 1 >= 12) ? 1 : 0);
      chk("fill_wfull", a_wfull, (i + 1 == 16) ? 1 : 0);
    end

    // 17th write is rejected and flagged.
    a_winc = 1'b1; a_wdata = 12'h777;
    tick();
    a_winc = 1'b0;
    chk("ovf_set", a_ovf, 1);
    chk("ovf_count", a_count, 16);

    // Drain all 16 words.
    for (int i = 0; i < 16; i++) begin
      a_read("drain_data");
      chk("drain_count", a_count, 15 - i);
      chk("drain_raempty", a_raempty, (15 - i <= 2) ? 1 : 0);
      chk("drain_rempty", a_rempty, (i == 15) ? 1 : 0);
    end

    // Read from empty sets underflow.
    a_rinc = 1'b1;
    tick();
    a_rinc = 1'b0;
    chk("udf_set", a_udf, 1);
    chk("udf_count", a_count, 0);

    // Clear both sticky flags.
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    chk("clr_ovf", a_ovf, 0);
    chk("clr_udf", a_udf, 0);

    // Refill, then write and read together while full.
    for (int i = 0; i < 16; i++) a_write(12'(12'h800 + i));
    chk("refill_full", a_wfull, 1);
    chk("both_head", a_rdata, q[0]);
    a_winc = 1'b1; a_wdata = 12'hEEE; a_rinc = 1'b1;
    tick();
    a_winc = 1'b0; a_rinc = 1'b0;
    void'(q.pop_front());
    chk("both_count", a_count, 15);
    chk("both_ovf", a_ovf, 1);
    chk("both_wfull", a_wfull, 0);
    for (int i = 0; i < 15; i++) a_read("both_drain");
    chk("both_empty", a_rempty, 1);

    // Registered-read instance: alternate write and read.
    last = 12'h000;
    for (int k = 0; k < 6; k++) begin
      b_winc = 1'b1; b_wdata = alt[k];
      tick();
      b_winc = 1'b0;
      chk("alt_count_w", b_count, 1);
      chk("alt_hold", b_rdata, last);
      b_rinc = 1'b1;
      tick();
      b_rinc = 1'b0;
      chk("alt_count_r", b_count, 0);
      chk("alt_data", b_rdata, alt[k]);
      last = alt[k];
    end

    // Illegal read sets underflow; rData holds.
    b_rinc = 1'b1;
    tick();
    b_rinc = 1'b0;
    chk("b_udf_set", b_udf, 1);
    chk("b_udf_hold", b_rdata, last);
    // Clear coinciding with a new illegal read: set wins.
    b_rinc = 1'b1; b_clr = 1'b1;
    tick();
    b_rinc = 1'b0; b_clr = 1'b0;
    chk("b_udf_setwins", b_udf, 1);
    // Clean clear.
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    chk("b_udf_clr", b_udf, 0);

    // 20 writes and 20 reads interleaved across the pointer wrap.
    for (int i = 0; i < 3; i++) a_write(12'(12'h100 + i));
    for (int i = 3; i < 20; i++) begin
      chk("wrap_data", a_rdata, q[0]);
      a_winc = 1'b1; a_wdata = 12'(12'h100 + i); a_rinc = 1'b1;
      tick();
      a_winc = 1'b0; a_rinc = 1'b0;
      void'(q.pop_front());
      q.push_back(12'(12'h100 + i));
      chk("wrap_count", a_count, 3);
    end
    for (int i = 0; i < 3; i++) a_read("wrap_tail");
    chk("wrap_empty", a_rempty, 1);

    // Reset mid-stream with 7 words held and a write pending.
    for (int i = 0; i < 7; i++) a_write(12'(12'h200 + i));
    chk("mid_count7", a_count, 7);
    rst = 1'b1; a_winc = 1'b1; a_wdata = 12'hBAD;
    tick();
    rst = 1'b0; a_winc = 1'b0;
    q.delete();
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_empty", a_rempty, 1);

    // Traffic after reset.
    for (int i = 0; i < 5; i++) a_write(12'(12'h4C0 + 3 * i));
    chk("post_count", a_count, 5);
    for (int i = 0; i < 5; i++) a_read("post_data");
    chk("post_empty", a_rempty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised FIFO: the synchronous-domain successor to our asynchronous FIFO, for paths where producer and consumer share one clock. Adds features the async FIFO lacks:
- configurable depth and width;
- first-word-fall-through (FWFT) or registered-read mode;
- programmable almost-full and almost-empty flags;
- occupancy count;
- sticky overflow and underflow error flags.

Parameters:
DATA_SIZE, 12, data width in bits
ADDR_SIZE, 4, address width; DEPTH = 2**ADDR_SIZE (16)
FWFT, 1, 1 = head word visible on rData while !rEmpty; 0 = rData registered, updates the cycle after an accepted read
AFULL_TH, 12, wAlmostFull asserted when count >= AFULL_TH
AEMPTY_TH, 2, rAlmostEmpty asserted when count <= AEMPTY_TH

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
winc  in  1  write request
wData  in  DATA_SIZE  write data
wFull  out  1  count == DEPTH
wAlmostFull  out  1  count >= AFULL_TH
rinc  in  1  read request
rData  out  DATA_SIZE  read data
rEmpty  out  1  count == 0
rAlmostEmpty  out  1  count <= AEMPTY_TH
count  out  ADDR_SIZE+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty
clr_err  in  1  clears overflow and underflow

Behaviour:
- Reset and timing:
  - One clock domain; reset is synchronous and active-high.
  - With rst high at a rising edge of clk: wptr=0, rptr=0, count=0, rEmpty=1, wFull=0, rAlmostEmpty=1, wAlmostFull=0, overflow=0, underflow=0, registered rData=0.
  - Memory contents are not reset.
  - rst overrides all other inputs in that cycle; a transfer in progress is discarded.
- Write acceptance: wr_ok = winc & !wFull.
  - On an accepted write, mem[wptr] <= wData and wptr increments, wrapping modulo DEPTH.
- Read acceptance: rd_ok = rinc & !rEmpty.
  - On an accepted read, rptr increments, wrapping modulo DEPTH.
- Count update: count_next = count + wr_ok - rd_ok.
  - All flags are registered and derived from count_next, so they are valid in the cycle after the causing edge. There is no combinational path from winc/rinc to any flag.
- Simultaneous events:
  - Both accepted (0 < count < DEPTH): count unchanged, both pointers advance.
  - Full with winc & rinc: read accepted, write rejected and overflow set. There is no same-cycle pass-through. Count becomes DEPTH-1.
  - Empty with winc & rinc: write accepted, read rejected and underflow set. Count becomes 1.
- FWFT=1:
  - rData = mem[rptr], driven combinationally from the memory read port.
  - Valid whenever rEmpty=0, so the head word is visible before rinc is asserted.
  - A word written into an empty FIFO appears on rData one cycle after the write edge, when rEmpty falls.
- FWFT=0:
  - On rd_ok, rData <= mem[rptr], visible the cycle after the read edge.
  - rData holds its value otherwise.
- Error flags:
  - overflow is set by winc & wFull; underflow is set by rinc & rEmpty.
  - clr_err clears both flags at the next edge.
  - If a set event and clr_err occur in the same cycle, set wins.
- Wrap-around: pointers carry no extra MSB; full/empty are resolved by count only.
- Elaboration-time checks:
  - 0 <= AEMPTY_TH < AFULL_TH <= DEPTH.
  - ADDR_SIZE >= 1.
  - Violating either is a fatal elaboration error.

Decomposition:
- Package sync_fifo_pkg:
  - function fifo_depth(addr_size) returning 2**addr_size;
  - localparam defaults for DATA_SIZE and ADDR_SIZE;
  - typedef enum for read mode (RD_FWFT, RD_REG), used to document the FWFT parameter.
- Sub-module sync_fifo_mem: DEPTH x DATA_SIZE dual-port array with a synchronous write and an asynchronous read at an address. The FWFT/registered rData mux stays in the top level.

Test Plan:
- Reset then idle, with rst held high for 3 cycles then released:
  - required: rEmpty=1, wFull=0, count=0, rAlmostEmpty=1, overflow=0, underflow=0.
- Write 16 random words 0x000..0xFFF back-to-back with no reads:
  - required: wAlmostFull rises the cycle after the 12th write, wFull the cycle after the 16th, count=16.
  - A 17th winc sets overflow and leaves count=16.
- After filling, read 16 words with FWFT=1:
  - required: each rData equals the scoreboard queue pop at the rinc edge.
  - rAlmostEmpty rises when count reaches 2; rEmpty the cycle after the 16th read.
  - A further rinc sets underflow.
- Full FIFO with winc=1 and rinc=1 for one cycle:
  - required: count 16 -> 15, overflow set, the oldest word popped, the new word not stored.
- FWFT=0 build, alternating write/read every cycle with data 0xA5A, 0x3C3, ...:
  - required: each rData appears exactly one cycle after its accepted rinc; count stays 0/1.
  - Then a clr_err pulse coinciding with an illegal read keeps underflow=1; a later clean clr_err pulse clears it to 0.
- Write 20 and read 20 words interleaved, exercising pointer wrap:
  - required: data order preserved across wrap.
  - Asserting rst mid-stream with count=7 gives count=0 and rEmpty=1 next cycle; subsequent traffic restarts from wptr=rptr=0 and passes.
